// File: rtl/booth_seq_ctrl_pkg.sv
// Shared types and helpers for the iterative radix-2 Booth multiplier.
//
// Contents:
//   state_e       controller state (StIdle, StRun, StDone)
//   booth_op_e    decoded Booth pair action (BoothNop, BoothAdd, BoothSub)
//   booth_decode  maps {Q[0], q_prev} to a booth_op_e
//   cnt_w         width of the step counter for a given operand width
package booth_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        BoothNop,
        BoothAdd,
        BoothSub
    } booth_op_e;

    // Radix-2 Booth recoding of the current pair {Q[0], q_prev}.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_prev);
        booth_op_e op;
        case ({q0, q_prev})
            2'b01:   op = BoothAdd;
            2'b10:   op = BoothSub;
            default: op = BoothNop;
        endcase
        return op;
    endfunction

    // Counter must hold 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Handshake/data bundle between operand producer, Booth sequencer and result consumer.
//
// Parameter N: operand width in bits.
// Signals:
//   in_valid, multiplicand, multiplier   producer -> sequencer
//   in_ready                              sequencer -> producer
//   out_valid, product, busy              sequencer -> consumer
//   out_ready                             consumer  -> sequencer
// Modports:
//   master  the producer/consumer side
//   slave   the sequencer side
interface booth_seq_ctrl_if #(
    parameter int unsigned N = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             busy;

    modport master (
        output in_valid,
        output multiplicand,
        output multiplier,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  multiplicand,
        input  multiplier,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy
    );

endinterface

// File: rtl/booth_seq_ctrl_step.sv
// One combinational radix-2 Booth iteration.
//
// Parameter N: operand width in bits.
// Ports:
//   a            in   N+1  partial-product accumulator
//   q            in   N    remaining scanned operand bits
//   q_prev       in   1    bit shifted out of q on the previous step
//   m            in   N    signed operand that is added or subtracted
//   a_next       out  N+1  accumulator after add/sub and arithmetic shift
//   q_next       out  N    q after shift (receives LSB of the accumulator)
//   q_prev_next  out  1    old q[0]
module booth_seq_ctrl_step
    import booth_seq_ctrl_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N:0]   a,
    input  logic [N-1:0] q,
    input  logic         q_prev,
    input  logic [N-1:0] m,
    output logic [N:0]   a_next,
    output logic [N-1:0] q_next,
    output logic         q_prev_next
);

    logic [N:0] m_ext;
    logic [N:0] sum;

    assign m_ext = {m[N-1], m};

    always_comb begin
        sum = a;
        case (booth_decode(q[0], q_prev))
            BoothAdd: sum = a + m_ext;
            BoothSub: sum = a - m_ext;
            default:  sum = a;
        endcase
    end

    // Arithmetic right shift of {sum, q, q_prev} by one.
    assign a_next      = {sum[N], sum[N:1]};
    assign q_next      = {sum[0], q[N-1:1]};
    assign q_prev_next = q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Iterative radix-2 Booth multiplier sequencer: one add/sub/shift step per clock on a single
// shared adder, with valid/ready handshakes on the operand and result sides.
//
// Parameter N: operand width in bits (signed two's complement), N >= 2.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset; discards any in-flight operation
//   bus    booth_seq_ctrl_if.slave:
//            in_valid/in_ready/multiplicand/multiplier  operand accept (IDLE only)
//            out_valid/out_ready/product                result offer (held until accepted)
//            busy                                       high in RUN and DONE
//
// Optional build macro BOOTH_EARLY_TERM_EN: once the unscanned multiplicand bits are uniform
// no further add/sub can occur, so the remaining shifts are applied in one cycle and the
// product is offered early. Without it latency is fixed at N cycles.
module booth_seq_ctrl
    import booth_seq_ctrl_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input logic            clk,
    input logic            rst_n,
    booth_seq_ctrl_if.slave bus
);

    localparam int unsigned       CntW    = cnt_w(N);
    localparam logic [CntW-1:0]   LastCnt = CntW'(N - 1);

    state_e           state_q, state_d;
    logic [N:0]       a_q, a_d;
    logic [N-1:0]     q_q, q_d;
    logic [N-1:0]     m_q, m_d;
    logic             qp_q, qp_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;

    logic [N:0]       a_step;
    logic [N-1:0]     q_step;
    logic             qp_step;

    booth_seq_ctrl_step #(
        .N (N)
    ) u_step (
        .a           (a_q),
        .q           (q_q),
        .q_prev      (qp_q),
        .m           (m_q),
        .a_next      (a_step),
        .q_next      (q_step),
        .q_prev_next (qp_step)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic                 rest_uniform;
    logic [CntW-1:0]      rem;
    logic signed [2*N:0]  shifted;
    logic                 unused_shifted_msb;

    // Original multiplicand bits cnt..N-1 sit in q_q[N-1-cnt:0]. If they are all equal,
    // every pair from this step on except possibly the current one is a no-op.
    always_comb begin
        rest_uniform = 1'b1;
        for (int i = 1; i < int'(N); i++) begin
            if ((i + int'(cnt_q)) < int'(N) && (q_q[i] != q_q[0])) begin
                rest_uniform = 1'b0;
            end
        end
    end

    // Shifts still owed after the current step.
    assign rem                = LastCnt - cnt_q;
    assign shifted            = $signed({a_step, q_step}) >>> rem;
    assign unused_shifted_msb = shifted[2*N];
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qp_d    = qp_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    state_d = StRun;
                    a_d     = '0;
                    q_d     = bus.multiplicand;
                    m_d     = bus.multiplier;
                    qp_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_d   = a_step;
                q_d   = q_step;
                qp_d  = qp_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    // A[N] only guards the -2^(N-1) squared case; the 2N-bit product is exact.
                    prod_d  = {a_step[N-1:0], q_step};
                    cnt_d   = '0;
                end
`ifdef BOOTH_EARLY_TERM_EN
                else if (rest_uniform) begin
                    state_d = StDone;
                    prod_d  = shifted[2*N-1:0];
                    cnt_d   = '0;
                end
`endif
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qp_q    <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qp_q    <= qp_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.product   = prod_q;

endmodule
